// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the load/store sequencer and its merge helper.
//   mem_size_t  : access size code, same encoding the extension stage decodes
//   mem_state_t : sequencer FSM states
//   align_off() : byte offset inside the doubleword, forced to natural alignment
package mem_pkg;

   localparam int DWORD_BYTES = 8;

   typedef enum logic [1:0] {
      SZ_D = 2'b00,
      SZ_W = 2'b01,
      SZ_H = 2'b10,
      SZ_B = 2'b11
   } mem_size_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_MERGE = 3'd2,
      ST_WR    = 3'd3,
      ST_DONE  = 3'd4
   } mem_state_t;

   // Low address bits below the access size are dropped, so a misaligned
   // request lands on the naturally aligned field containing it.
   function automatic logic [2:0] align_off(input logic [2:0] addr_lo, input mem_size_t size);
      logic [2:0] off;
      case (size)
         SZ_D:    off = 3'b000;
         SZ_W:    off = {addr_lo[2], 2'b00};
         SZ_H:    off = {addr_lo[2:1], 1'b0};
         default: off = addr_lo;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/byte_merge.sv
// byte_merge: combinational insert of a store field into a doubleword.
//   i_dword  : doubleword read back from memory
//   i_field  : store data, field right-aligned in the low bits (upper bits ignored)
//   i_off    : byte offset of the field, already naturally aligned
//   i_size   : field size code (dword/word/half/byte)
//   o_merged : i_dword with bytes [i_off .. i_off+N-1] replaced by the field
module byte_merge
   import mem_pkg::*;
(
   input  logic [DWORD_BYTES*8-1:0] i_dword,
   input  logic [DWORD_BYTES*8-1:0] i_field,
   input  logic [2:0]               i_off,
   input  mem_size_t                i_size,
   output logic [DWORD_BYTES*8-1:0] o_merged
);

   logic [DWORD_BYTES*8-1:0] w_mask;
   logic [5:0]               w_shift;

   always_comb begin
      w_mask = '0;
      case (i_size)
         SZ_D:    w_mask = '1;
         SZ_W:    w_mask = 64'h0000_0000_FFFF_FFFF;
         SZ_H:    w_mask = 64'h0000_0000_0000_FFFF;
         default: w_mask = 64'h0000_0000_0000_00FF;
      endcase
   end

   assign w_shift  = {i_off, 3'b000};
   assign o_merged = (i_dword & ~(w_mask << w_shift)) | ((i_field & w_mask) << w_shift);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store sequencer in front of the 64-bit
// data memory. Loads fetch the aligned doubleword and right-align the field;
// sub-doubleword stores do read-modify-write; sd writes directly.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_we, req_size      0=load/1=store, size code (00 d, 01 w, 10 h, 11 b)
//   req_addr, req_wdata   byte address, store field in low bits
//   mem_addr              doubleword-aligned memory address
//   mem_rd, mem_wr        strobes, held until mem_ready
//   mem_wdata, mem_rdata  memory write / read data
//   mem_ready             memory completes the current strobe this cycle
//   load_data, load_type  right-aligned raw load field and its size code
//   misalign              misaligned-request flag (only with MISALIGN_TRAP_EN)
//   done                  one-cycle completion pulse
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned requests (no memory
// access, misalign=1 in the DONE cycle). Without it low address bits are
// forced to natural alignment.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RD    | mem_rd held until mem_ready, read data captured
// MERGE | store field merged into the captured doubleword
// WR    | mem_wr held until mem_ready
// DONE  | done pulse, back to IDLE
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] load_data,
   output logic [1:0]        load_type,
`ifdef MISALIGN_TRAP_EN
   output logic              misalign,
`endif
   output logic              done
);

   mem_state_t        r_state;
   mem_size_t         r_size;
   logic              r_we;
   logic [2:0]        r_off;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_load_data;
   logic [1:0]        r_load_type;

   mem_size_t         w_req_size;
   logic [2:0]        w_req_off;
   logic [DATA_W-1:0] w_merged;
   logic              w_trap;

   assign w_req_size = mem_size_t'(req_size);
   assign w_req_off  = align_off(req_addr[2:0], w_req_size);

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;
   assign w_trap   = (w_req_off != req_addr[2:0]);
   assign misalign = r_misalign & (r_state == ST_DONE);
`else
   assign w_trap   = 1'b0;
`endif

   byte_merge u_byte_merge (
      .i_dword  (r_rdata),
      .i_field  (r_wdata),
      .i_off    (r_off),
      .i_size   (r_size),
      .o_merged (w_merged)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_size      <= SZ_D;
         r_we        <= 1'b0;
         r_off       <= 3'b000;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_load_data <= '0;
         r_load_type <= 2'b00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_size     <= w_req_size;
                  r_we       <= req_we;
                  r_off      <= w_req_off;
                  r_wdata    <= req_wdata;
                  r_mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                  if (w_trap) begin
                     r_state <= ST_DONE;
                  end else if (req_we && (w_req_size == SZ_D)) begin
                     r_mem_wdata <= req_wdata;
                     r_state     <= ST_WR;
                  end else begin
                     r_state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (mem_ready) begin
                  r_rdata <= mem_rdata;
                  if (r_we) begin
                     r_state <= ST_MERGE;
                  end else begin
                     r_load_data <= mem_rdata >> {r_off, 3'b000};
                     r_load_type <= r_size;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_MERGE: begin
               r_mem_wdata <= w_merged;
               r_state     <= ST_WR;
            end
            ST_WR: begin
               if (mem_ready) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (r_state == ST_IDLE && req_valid) begin
         r_misalign <= w_trap;
      end
   end
`endif

   // Strobes decode straight from state so an async reset drops them at once.
   assign req_ready = (r_state == ST_IDLE);
   assign mem_rd    = (r_state == ST_RD);
   assign mem_wr    = (r_state == ST_WR);
   assign done      = (r_state == ST_DONE);
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign load_data = r_load_data;
   assign load_type = r_load_type;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [63:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic [63:0] load_data;
   logic [1:0]  load_type;
   logic        done;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int vectors = 0;
   int miscompares = 0;

   mem_access_unit #(.DATA_W(64), .ADDR_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .load_data (load_data),
      .load_type (load_type),
`ifdef MISALIGN_TRAP_EN
      .misalign  (misalign),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   // memory responder: decides mem_ready on the falling edge, logs strobes
   int          cfg_wait = 0;
   logic [63:0] cfg_rdata = '0;
   int          wcnt = 0;
   int          rd_cycles = 0;
   int          wr_cycles = 0;
   logic [63:0] strobe_addr = '0;
   logic [63:0] wr_q[$];

   always @(negedge clk) begin
      if (reset) begin
         mem_ready = 1'b0;
         wcnt = 0;
      end else if (mem_rd || mem_wr) begin
         vectors++;
         if (mem_rd && mem_wr) begin
            miscompares++;
            $display("FAIL strobe_excl: mem_rd=%b mem_wr=%b, required not both", mem_rd, mem_wr);
         end
         if (mem_rd) rd_cycles++;
         if (mem_wr) wr_cycles++;
         strobe_addr = mem_addr;
         if (wcnt >= cfg_wait) begin
            mem_ready = 1'b1;
            mem_rdata = cfg_rdata;
            if (mem_wr) wr_q.push_back(mem_wdata);
            wcnt = 0;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
            wcnt++;
         end
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = {$urandom, $urandom};
         wcnt = 0;
      end
   end

   typedef struct {
      logic        we;
      logic [63:0] ld;
      logic [1:0]  lt;
      logic [63:0] wd;
      logic [63:0] maddr;
      int          rd_n;
      int          wr_n;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] last_ld = '0;
   logic [1:0]  last_lt = 2'b00;

   function automatic logic [2:0] model_off(input logic [63:0] addr, input logic [1:0] sz);
      logic [2:0] a;
      a = addr[2:0];
      case (sz)
         2'b00:   return 3'd0;
         2'b01:   return a & 3'b100;
         2'b10:   return a & 3'b110;
         default: return a;
      endcase
   endfunction

   function automatic int model_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 8;
         2'b01:   return 4;
         2'b10:   return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [63:0] wd,
                                               input logic [63:0] addr, input logic [1:0] sz);
      logic [63:0] r;
      int          off;
      r = old;
      off = int'(model_off(addr, sz));
      for (int i = 0; i < model_bytes(sz); i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // build the expected record for a transaction and push it to the scoreboard
   task automatic push_exp(input logic we, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] rdata, input int w);
      exp_t e;
      e.we = we;
      e.maddr = {addr[63:3], 3'b000};
      if (!we) begin
         e.ld = rdata >> (8 * int'(model_off(addr, sz)));
         e.lt = sz;
         e.wd = '0;
         e.rd_n = 1 + w;
         e.wr_n = 0;
         e.lat = 3 + w;
         last_ld = e.ld;
         last_lt = sz;
      end else begin
         e.ld = last_ld;
         e.lt = last_lt;
         if (sz == 2'b00) begin
            e.wd = wd;
            e.rd_n = 0;
            e.lat = 3 + w;
         end else begin
            e.wd = model_merge(rdata, wd, addr, sz);
            e.rd_n = 1 + w;
            e.lat = 0;
         end
         e.wr_n = 1 + w;
      end
      sb.push_back(e);
   endtask

   // issue one request, scramble the inputs after acceptance, wait for done
   task automatic drive_req(input logic we, input logic [1:0] sz, input logic [63:0] addr,
                            input logic [63:0] wd, output int lat, output bit tmo);
      int guard;
      tmo = 1'b0;
      lat = 0;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         tmo = 1'b1;
         return;
      end
      req_valid = 1'b1;
      req_we = we;
      req_size = sz;
      req_addr = addr;
      req_wdata = wd;
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      lat = 2;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!done) tmo = 1'b1;
   endtask

   task automatic test_reset;
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
      vectors++;
      if ({mem_rd, mem_wr} !== 2'b00) begin miscompares++; $display("FAIL rst_strobes: got %b want 00", {mem_rd, mem_wr}); end
      vectors++;
      if (load_data !== 64'h0) begin miscompares++; $display("FAIL rst_load_data: got %h want 0", load_data); end
      vectors++;
      if (load_type !== 2'b00) begin miscompares++; $display("FAIL rst_load_type: got %b want 00", load_type); end
      vectors++;
      if (mem_addr !== 64'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      vectors++;
      if (mem_wdata !== 64'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
   endtask

   // one transaction with full scoreboard comparison; used by the table tests
   task automatic test_txn(input string nm, input logic we, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] rdata, input int w);
      int   lat;
      bit   tmo;
      int   rd0, wr0;
      exp_t e;
      cfg_wait = w;
      cfg_rdata = rdata;
      push_exp(we, sz, addr, wd, rdata, w);
      rd0 = rd_cycles;
      wr0 = wr_cycles;
      drive_req(we, sz, addr, wd, lat, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo) begin
         miscompares++;
         $display("FAIL %s_timeout: no done within bound", nm);
         return;
      end
      if (e.lat != 0) begin
         vectors++;
         if (lat != e.lat) begin miscompares++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, e.lat); end
      end
      vectors++;
      if (rd_cycles - rd0 != e.rd_n) begin miscompares++; $display("FAIL %s_rd_cycles: got %0d want %0d", nm, rd_cycles - rd0, e.rd_n); end
      vectors++;
      if (wr_cycles - wr0 != e.wr_n) begin miscompares++; $display("FAIL %s_wr_cycles: got %0d want %0d", nm, wr_cycles - wr0, e.wr_n); end
      vectors++;
      if (strobe_addr !== e.maddr) begin miscompares++; $display("FAIL %s_mem_addr: got %h want %h", nm, strobe_addr, e.maddr); end
      vectors++;
      if (load_data !== e.ld) begin miscompares++; $display("FAIL %s_load_data: got %h want %h", nm, load_data, e.ld); end
      vectors++;
      if (load_type !== e.lt) begin miscompares++; $display("FAIL %s_load_type: got %b want %b", nm, load_type, e.lt); end
      if (e.we) begin
         vectors++;
         if (wr_q.size() != 1) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d want 1", nm, wr_q.size());
         end else if (wr_q[0] !== e.wd) begin
            miscompares++;
            $display("FAIL %s_wdata: got %h want %h", nm, wr_q[0], e.wd);
         end
      end
      wr_q.delete();
   endtask

   task automatic test_loads;
      test_txn("lb_13", 1'b0, 2'b11, 64'h13, 64'h0, 64'h8877665544332211, 0);
      test_txn("ld_28", 1'b0, 2'b00, 64'h28, 64'h0, 64'h0123456789ABCDEF, 1);
      test_txn("lh_36", 1'b0, 2'b10, 64'h36, 64'h0, 64'hFEDCBA9876543210, 0);
      test_txn("lw_1c", 1'b0, 2'b01, 64'h1C, 64'h0, 64'hA5A5A5A55A5A5A5A, 2);
   endtask

   task automatic test_stores;
      test_txn("sh_22", 1'b1, 2'b10, 64'h22, 64'h0000_0000_0000_BEEF, 64'h1111111111111111, 0);
      test_txn("sb_37", 1'b1, 2'b11, 64'h37, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1);
      test_txn("sw_4c", 1'b1, 2'b01, 64'h4C, 64'h9999_9999_1234_5678, 64'hFFFFFFFFFFFFFFFF, 0);
      test_txn("sb_00", 1'b1, 2'b11, 64'h00, 64'h0000_0000_0000_0042, 64'h0706050403020100, 2);
   endtask

   task automatic test_sd;
      test_txn("sd_40", 1'b1, 2'b00, 64'h40, 64'hDEADBEEFCAFEF00D, 64'h5555555555555555, 2);
   endtask

   task automatic test_reset_in_rd;
      int guard;
      cfg_wait = 20;
      cfg_rdata = 64'h1234;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 40) begin @(negedge clk); guard++; end
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b00;
      req_addr = 64'h40;
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL rstrd_in_rd: mem_rd got %b want 1", mem_rd); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL rstrd_async_drop: mem_rd got %b want 0", mem_rd); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rstrd_ready: got %b want 1", req_ready); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL rstrd_done: got %b want 0", done); end
      vectors++;
      if (load_data !== 64'h0) begin miscompares++; $display("FAIL rstrd_load_data: got %h want 0", load_data); end
      last_ld = '0;
      last_lt = 2'b00;
      cfg_wait = 0;
   endtask

   task automatic test_back_to_back;
      int   guard;
      int   busy_ready;
      exp_t e;
      cfg_wait = 0;
      cfg_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      push_exp(1'b0, 2'b01, 64'h08, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0);
      push_exp(1'b0, 2'b01, 64'h0C, 64'h0, 64'h1111_2222_3333_4444, 0);
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 40) begin @(negedge clk); guard++; end
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b01;
      req_addr = 64'h08;
      busy_ready = 0;
      guard = 0;
      @(negedge clk);
      while (!done && guard < 40) begin
         if (req_ready) busy_ready++;
         @(negedge clk);
         guard++;
      end
      e = sb.pop_front();
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL b2b_first_timeout: no done within bound");
      end else if (load_data !== e.ld) begin
         miscompares++;
         $display("FAIL b2b_first_data: got %h want %h", load_data, e.ld);
      end
      vectors++;
      if (busy_ready != 0) begin miscompares++; $display("FAIL b2b_ready_busy: ready seen %0d cycles want 0", busy_ready); end
      req_addr = 64'h0C;
      cfg_rdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_done: got %b want 1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL b2b_second_rd: got %b want 1", mem_rd); end
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done: got %b want 1", done); end
      vectors++;
      if (load_data !== e.ld) begin miscompares++; $display("FAIL b2b_second_data: got %h want %h", load_data, e.ld); end
      last_ld = e.ld;
      last_lt = e.lt;
   endtask

   task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
      int lat;
      bit tmo;
      int rd0, wr0;
      bit mis;
      cfg_wait = 0;
      cfg_rdata = 64'hCAFE_0000_0000_0000;
      rd0 = rd_cycles;
      wr0 = wr_cycles;
      drive_req(1'b0, 2'b01, 64'h06, 64'h0, lat, tmo);
      mis = misalign;
      vectors++;
      if (tmo) begin miscompares++; $display("FAIL mis_timeout: no done within bound"); end
      vectors++;
      if (lat != 2) begin miscompares++; $display("FAIL mis_latency: got %0d want 2", lat); end
      vectors++;
      if (mis !== 1'b1) begin miscompares++; $display("FAIL mis_flag: got %b want 1", mis); end
      vectors++;
      if ((rd_cycles - rd0) + (wr_cycles - wr0) != 0) begin
         miscompares++;
         $display("FAIL mis_no_strobe: got %0d strobe cycles want 0", (rd_cycles - rd0) + (wr_cycles - wr0));
      end
      vectors++;
      if (load_data !== last_ld || load_type !== last_lt) begin
         miscompares++;
         $display("FAIL mis_load_kept: got %h/%b want %h/%b", load_data, load_type, last_ld, last_lt);
      end
      @(negedge clk);
      vectors++;
      if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_flag_clear: got %b want 0", misalign); end
      // an aligned request after the trap must not report misalign
      test_txn("lw_04_after_trap", 1'b0, 2'b01, 64'h04, 64'h0, 64'h8765_4321_0000_0000, 0);
`else
      test_txn("lw_06_forced", 1'b0, 2'b01, 64'h06, 64'h0, 64'hCAFE_F00D_0000_0000, 0);
`endif
   endtask

   task automatic test_random_mix;
      logic        we;
      logic [1:0]  sz;
      logic [63:0] addr;
      for (int i = 0; i < 12; i++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         addr = 64'($urandom_range(0, 1023));
         addr[2:0] = model_off(addr, sz);
         test_txn($sformatf("rnd%0d", i), we, sz, addr, {$urandom, $urandom},
                  {$urandom, $urandom}, int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_loads();
      test_stores();
      test_sd();
      test_reset_in_rd();
      test_back_to_back();
      test_misalign();
      test_random_mix();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
